// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read side of an asynchronous FIFO with a registered
// valid/ready stream output. Synchronizes the Gray write pointer into rclk,
// tracks empty/level/almost_empty, and pops memory words into an output
// register that holds steady under backpressure.
module fifo_rd_stream #(
    parameter int PTR_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [PTR_WIDTH:0]    g_wptr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    level,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam logic [PTR_WIDTH:0] AE_THRESH = (PTR_WIDTH + 1)'(AE_LEVEL);

    logic [PTR_WIDTH:0] wq1;
    logic [PTR_WIDTH:0] wq2;
    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] b_rptr_next;
    logic [PTR_WIDTH:0] g_rptr_next;
    logic [PTR_WIDTH:0] level_next;
    logic               pop;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_WIDTH:0] gray_to_bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Two-flop synchronizer for the Gray write pointer; nothing else touches g_wptr.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= g_wptr;
            wq2 <= wq1;
        end
    end

    // Pop decision and the next-pointer / next-level arithmetic shared by all registers.
    always_comb begin
        pop         = !empty && (!m_valid || m_ready);
        b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, pop};
        g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1);
        wbin        = gray_to_bin(wq2);
        level_next  = wbin - b_rptr_next;
    end

    // Read pointers and status flags, all computed from the post-pop pointer so
    // draining the last entry raises empty on the same edge.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            level        <= '0;
        end else begin
            b_rptr       <= b_rptr_next;
            g_rptr       <= g_rptr_next;
            empty        <= (g_rptr_next == wq2);
            level        <= level_next;
            almost_empty <= (level_next <= AE_THRESH);
        end
    end

    // Output register: load on pop, drop valid after a handshake with nothing to
    // replace it, otherwise hold the word steady.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (pop) begin
            m_valid <= 1'b1;
            m_data  <= rd_data;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench for fifo_rd_stream. The bench plays the
// write domain (memory array plus Gray write pointer) and checks the stream
// output, pointers and flags against hand-computed values.
module tb_fifo_rd_stream;

    localparam int PW = 5;
    localparam int DW = 32;

    logic          rclk;
    logic          rrst;
    logic [PW:0]   g_wptr;
    logic [DW-1:0] rd_data;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic          empty;
    logic          almost_empty;
    logic [PW:0]   level;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    logic [DW-1:0] mem [0:(1<<PW)-1];
    logic [PW:0]   w_cnt;

    int checks = 0;
    int errors = 0;

    fifo_rd_stream #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AE_LEVEL(2)) dut (
        .rclk         (rclk),
        .rrst         (rrst),
        .g_wptr       (g_wptr),
        .rd_data      (rd_data),
        .b_rptr       (b_rptr),
        .g_rptr       (g_rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .level        (level),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
    );

    assign rd_data = mem[b_rptr[PW-1:0]];

    // Free-running read clock.
    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic step();
        @(negedge rclk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[w_cnt[PW-1:0]] = d;
        w_cnt  = w_cnt + 1'b1;
        g_wptr = w_cnt ^ (w_cnt >> 1);
    endtask

    task automatic do_reset();
        rrst    = 1'b1;
        m_ready = 1'b0;
        w_cnt   = '0;
        g_wptr  = '0;
        step();
        step();
        rrst = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        logic [PW:0] exp_b;
        logic [PW:0] prev_g;
        logic [PW:0] prev_b;
        int          acc;
        int          written;
        bit          wrapped;

        for (int i = 0; i < (1 << PW); i++) mem[i] = '0;
        rrst    = 1'b1;
        m_ready = 1'b0;
        w_cnt   = '0;
        g_wptr  = '0;

        // Reset state, sampled while rrst is still high after two edges.
        step();
        step();
        check("rst_empty", empty, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_b_rptr", b_rptr, 0);
        check("rst_g_rptr", g_rptr, 0);
        check("rst_level", level, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_m_data", m_data, 0);
        rrst = 1'b0;
        step();
        check("rst_idle_empty", empty, 1);

        // Single word: latency of the synchronizer and output stage.
        m_ready = 1'b1;
        write_word(32'hDEADBEEF);
        step();
        check("single_empty_N", empty, 1);
        step();
        check("single_empty_N1", empty, 1);
        step();
        check("single_empty_N2", empty, 0);
        check("single_valid_N2", m_valid, 0);
        check("single_level_N2", level, 1);
        step();
        check("single_valid_N3", m_valid, 1);
        check("single_data_N3", m_data, 32'hDEADBEEF);
        check("single_empty_N3", empty, 1);
        check("single_b_rptr_N3", b_rptr, 1);
        check("single_g_rptr_N3", g_rptr, 1);
        check("single_level_N3", level, 0);
        step();
        check("single_valid_N4", m_valid, 0);
        check("single_data_hold", m_data, 32'hDEADBEEF);
        check("single_b_rptr_N4", b_rptr, 1);

        // Backpressure: A is held while B and C wait in memory.
        do_reset();
        write_word(32'hAAAA0001);
        step();
        write_word(32'hBBBB0002);
        step();
        write_word(32'hCCCC0003);
        repeat (8) step();
        check("bp_valid", m_valid, 1);
        check("bp_data_A", m_data, 32'hAAAA0001);
        check("bp_b_rptr", b_rptr, 1);
        check("bp_level", level, 2);
        check("bp_almost_empty", almost_empty, 1);
        check("bp_empty", empty, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_data_hold", m_data, 32'hAAAA0001);
            check("bp_b_rptr_hold", b_rptr, 1);
        end
        m_ready = 1'b1;
        step();
        check("bp_data_B", m_data, 32'hBBBB0002);
        check("bp_valid_B", m_valid, 1);
        check("bp_b_rptr_B", b_rptr, 2);
        step();
        check("bp_data_C", m_data, 32'hCCCC0003);
        check("bp_valid_C", m_valid, 1);
        check("bp_b_rptr_C", b_rptr, 3);
        check("bp_empty_C", empty, 1);
        check("bp_level_C", level, 0);
        step();
        check("bp_valid_end", m_valid, 0);
        check("bp_data_end", m_data, 32'hCCCC0003);
        check("bp_b_rptr_end", b_rptr, 3);

        // Level and almost_empty threshold crossing.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            write_word(32'h00001000 + i);
            step();
        end
        repeat (6) step();
        check("lvl_level9", level, 9);
        check("lvl_ae_9", almost_empty, 0);
        check("lvl_b_rptr_1", b_rptr, 1);
        check("lvl_data_0", m_data, 32'h00001000);
        m_ready = 1'b1;
        repeat (6) step();
        check("lvl_level3", level, 3);
        check("lvl_ae_3", almost_empty, 0);
        check("lvl_b_rptr_7", b_rptr, 7);
        check("lvl_data_6", m_data, 32'h00001006);
        step();
        m_ready = 1'b0;
        check("lvl_level2", level, 2);
        check("lvl_ae_2", almost_empty, 1);
        check("lvl_b_rptr_8", b_rptr, 8);
        check("lvl_data_7", m_data, 32'h00001007);

        // Mid-stream reset with a word in the output register and 4 pending.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            write_word(32'h00002000 + i);
            step();
        end
        repeat (6) step();
        check("mrst_pre_valid", m_valid, 1);
        check("mrst_pre_level", level, 4);
        rrst   = 1'b1;
        w_cnt  = '0;
        g_wptr = '0;
        step();
        check("mrst_valid", m_valid, 0);
        check("mrst_empty", empty, 1);
        check("mrst_b_rptr", b_rptr, 0);
        check("mrst_g_rptr", g_rptr, 0);
        check("mrst_level", level, 0);
        check("mrst_m_data", m_data, 0);
        rrst = 1'b0;
        step();
        check("mrst_after_empty", empty, 1);
        check("mrst_after_valid", m_valid, 0);

        // Wrap: 70 words through the 32-deep FIFO with random backpressure.
        acc     = 0;
        written = 0;
        wrapped = 1'b0;
        prev_g  = g_rptr;
        prev_b  = b_rptr;
        for (int cyc = 0; cyc < 3000 && acc < 70; cyc++) begin
            exp_b = (PW + 1)'(acc + int'(m_valid));
            check("wrap_b_rptr", b_rptr, exp_b);
            check("wrap_g_rptr", g_rptr, exp_b ^ (exp_b >> 1));
            check("wrap_gray_step", ($countones(g_rptr ^ prev_g) <= 1), 1);
            if (prev_b == 6'd63 && b_rptr == 6'd0) wrapped = 1'b1;
            prev_g  = g_rptr;
            prev_b  = b_rptr;
            m_ready = 1'($urandom_range(0, 1));
            if (written < 70 && ((PW + 1)'(w_cnt - b_rptr) < 6'd32) && $urandom_range(0, 3) != 0) begin
                write_word(32'hC0DE0000 + written);
                written++;
            end
            if (m_valid && m_ready) begin
                check("wrap_data", m_data, 32'hC0DE0000 + acc);
                acc++;
            end
            step();
        end
        check("wrap_count", acc, 70);
        check("wrap_seen_63_to_0", wrapped, 1);
        m_ready = 1'b1;
        repeat (4) step();
        check("wrap_final_empty", empty, 1);
        check("wrap_final_valid", m_valid, 0);
        check("wrap_final_level", level, 0);
        check("wrap_final_b_rptr", b_rptr, 6'(70 - 64));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter PTR_WIDTH, default 5, address width; FIFO depth SHALL be 2**PTR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Parameter AE_LEVEL, default 2, almost-empty threshold in entries.
REQ-004 rclk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rrst  input  1  synchronous active-high reset, sampled on rclk rising edge.
REQ-006 g_wptr  input  PTR_WIDTH+1  Gray-coded write pointer from the write domain, asynchronous to rclk.
REQ-007 rd_data  input  DATA_WIDTH  memory word at address b_rptr[PTR_WIDTH-1:0], combinational read.
REQ-008 b_rptr  output  PTR_WIDTH+1  binary read pointer, registered, drives memory read address.
REQ-009 g_rptr  output  PTR_WIDTH+1  Gray read pointer, registered, for the write domain's full logic.
REQ-010 empty  output  1  registered empty flag.
REQ-011 almost_empty  output  1  registered; high when level <= AE_LEVEL.
REQ-012 level  output  PTR_WIDTH+1  registered count of memory entries, output register excluded.
REQ-013 m_data  output  DATA_WIDTH  registered stream data.
REQ-014 m_valid  output  1  registered stream valid.
REQ-015 m_ready  input  1  downstream accept.

Function
REQ-016 g_wptr SHALL pass through a two-flop synchronizer (wq1, wq2) before any use; no other logic on g_wptr.
REQ-017 pop = !empty && (!m_valid || m_ready), combinational.
REQ-018 On pop: m_data <= rd_data; m_valid <= 1; b_rptr <= b_rptr + 1, modulo 2**(PTR_WIDTH+1).
REQ-019 No pop, m_valid && m_ready: m_valid <= 0; m_data SHALL hold.
REQ-020 No pop, no handshake: m_data, m_valid, b_rptr SHALL hold; m_data SHALL stay stable while m_valid && !m_ready.
REQ-021 b_rptr_next = b_rptr + pop; g_rptr <= b_rptr_next ^ (b_rptr_next >> 1).
REQ-022 empty <= (gray(b_rptr_next) == wq2), full PTR_WIDTH+1 bit compare including wrap bit.
REQ-023 wq2 Gray SHALL convert to binary wbin; level <= wbin - b_rptr_next, modulo 2**(PTR_WIDTH+1).
REQ-024 almost_empty <= (wbin - b_rptr_next) <= AE_LEVEL.
REQ-025 Latency: a g_wptr change stable before rclk edge N SHALL deassert empty after edge N+2 and assert m_valid after edge N+3.
REQ-026 Throughput: with m_ready held high and empty low, one word per rclk, no bubbles.
REQ-027 Last entry: the pop that consumes it SHALL assert empty on the same edge; no pop on the next cycle.
REQ-028 Wrap: b_rptr from 2**(PTR_WIDTH+1)-1 SHALL roll to 0 with g_rptr continuing the Gray sequence, one bit change per step.
REQ-029 Simultaneous write arrival and drain of the last entry: empty SHALL follow REQ-022 using the current wq2; a stale wq2 SHALL only make empty pessimistic, never drop or duplicate data.
REQ-030 Pointers SHALL never advance while empty is high.

Reset
REQ-031 While rrst high: b_rptr=0, g_rptr=0, wq1=wq2=0, empty=1, almost_empty=1, level=0, m_valid=0, m_data=0.
REQ-032 rrst mid-stream SHALL discard the output-register word and apply REQ-031 on the next edge; first pop no earlier than 1 cycle after rrst falls.
REQ-033 The write domain SHALL be reset together with rrst; this block does not recover from a non-zero g_wptr at reset.

Verification
REQ-034 Reset -> rrst 2 cycles, g_wptr=0 -> empty=1, m_valid=0, b_rptr=0, g_rptr=0, level=0.
REQ-035 Single word -> g_wptr 0->1 Gray, mem[0]=0xDEADBEEF, m_ready=1 -> empty=0 after edge N+2, m_valid=1 with m_data=0xDEADBEEF after N+3, empty=1, b_rptr=1.
REQ-036 Backpressure -> 3 words A,B,C, m_ready=0 for 5 cycles -> m_data=A stable, b_rptr=1, level=2, almost_empty=1; m_ready=1 -> A,B,C on consecutive cycles.
REQ-037 Wrap -> 70 words streamed through depth 32, m_ready random 50% -> in-order data, b_rptr wraps 63->0, each g_rptr step one-bit change, no loss or duplication.
REQ-038 Level -> 10 words written, m_ready=0 -> level=9 after 1 pop; almost_empty=0; drain to 2 entries -> almost_empty=1.
REQ-039 Mid-stream reset -> rrst pulsed with m_valid=1 and 4 entries pending -> next cycle m_valid=0, empty=1, b_rptr=0.
